// File: rtl/uart_tx_arb.sv
// uart_tx_arb: four-requester round-robin arbiter feeding a single UART
// transmitter. A grant latches the winner's byte, pulses o_ack/o_tx_en for
// one cycle and holds the FSM busy for FRAME_TICKS baud ticks.
// Optional feature macro: UART_ARB_GAP_EN -- when defined, a GAP state
// inserts GAP_TICKS idle baud ticks after every frame.
module uart_tx_arb #(
    parameter int unsigned FRAME_TICKS = 160,
    parameter int unsigned GAP_TICKS   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clk_tx,
    input  logic [3:0]  i_req,
    input  logic [31:0] i_data,
    output logic [3:0]  o_ack,
    output logic        o_tx_en,
    output logic [7:0]  o_tx_data,
    output logic        o_busy,
    output logic [1:0]  o_grant_id
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
`ifdef UART_ARB_GAP_EN
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);
`endif

    localparam logic [7:0] FRAME_LAST = 8'(FRAME_TICKS - 1);

    logic [1:0] state;
    logic [7:0] cnt;
    logic       win_valid;
    logic [1:0] win_id;
    logic [1:0] cand;

    // Round-robin search: first active request at or after last grant + 1.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = 2'(o_grant_id + 2'(i) + 2'd1);
            if (!win_valid && i_req[cand]) begin
                win_valid = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign o_busy = (state != IDLE);

    // FSM, tick counter and latched grant outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            o_tx_en    <= 1'b0;
            o_ack      <= '0;
            o_tx_data  <= '0;
            o_grant_id <= 2'd3;
        end else begin
            o_tx_en <= 1'b0;
            o_ack   <= '0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state      <= SEND;
                        cnt        <= '0;
                        o_tx_en    <= 1'b1;
                        o_ack      <= 4'b0001 << win_id;
                        o_tx_data  <= i_data[{win_id, 3'b000} +: 8];
                        o_grant_id <= win_id;
                    end
                end
                SEND: begin
                    // The tick coinciding with the o_tx_en cycle belongs to
                    // the transmitter's own start-up and is not counted.
                    if (i_clk_tx && !o_tx_en) begin
                        if (cnt == FRAME_LAST) begin
                            cnt   <= '0;
`ifdef UART_ARB_GAP_EN
                            state <= GAP;
`else
                            state <= IDLE;
`endif
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
`ifdef UART_ARB_GAP_EN
                GAP: begin
                    if (i_clk_tx) begin
                        if (cnt == GAP_LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed self-checking bench for uart_tx_arb.
// Baud ticks arrive every 4 clk cycles; expected values are hand-computed.
module tb_uart_tx_arb;

    localparam int FRAME = 160;
`ifdef UART_ARB_GAP_EN
    localparam int GAPT = 16;
`else
    localparam int GAPT = 0;
`endif
    localparam int SPACE = FRAME + GAPT;
    localparam int BUDGET = 3000;

    logic        clk;
    logic        reset;
    logic        i_clk_tx;
    logic [3:0]  i_req;
    logic [31:0] i_data;
    logic [3:0]  o_ack;
    logic        o_tx_en;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic [1:0]  o_grant_id;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_arb #(.FRAME_TICKS(160), .GAP_TICKS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_clk_tx   (i_clk_tx),
        .i_req      (i_req),
        .i_data     (i_data),
        .o_ack      (o_ack),
        .o_tx_en    (o_tx_en),
        .o_tx_data  (o_tx_data),
        .o_busy     (o_busy),
        .o_grant_id (o_grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle baud tick every fourth clk, changing 1 ns after the edge.
    initial begin
        logic [1:0] div;
        div = '0;
        i_clk_tx = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div = div + 2'd1;
            i_clk_tx = (div == 2'd0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for the next o_tx_en; counts ticks the DUT sees in between.
    task automatic wait_grant(output bit ok, output int ticks);
        ok = 1'b0;
        ticks = 0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (o_tx_en) begin
                ok = 1'b1;
                break;
            end
            if (i_clk_tx) ticks++;
        end
    endtask

    // Waits for o_busy to drop; counts ticks outside the o_tx_en cycle.
    task automatic wait_idle(output bit ok, output int ticks);
        ok = 1'b0;
        ticks = 0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (!o_busy) begin
                ok = 1'b1;
                break;
            end
            if (i_clk_tx && !o_tx_en) ticks++;
        end
    endtask

    initial begin
        bit ok;
        int t;
        int gid_a[5];
        int dat_a[5];
        int gid_b[3];
        int dat_b[3];
        bit bad_ack;
        bit bad_en;
        bit bad_data;
        int en_cnt;

        gid_a = '{0, 1, 2, 3, 0};
        dat_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        gid_b = '{1, 3, 1};
        dat_b = '{8'h22, 8'h44, 8'h22};

        reset = 1'b0;
        i_req = '0;
        i_data = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ack", 32'(o_ack), 32'h0);
        check("rst_tx_en", 32'(o_tx_en), 32'h0);
        check("rst_tx_data", 32'(o_tx_data), 32'h00);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_grant_id", 32'(o_grant_id), 32'h3);

        // Single requester 0, byte A5
        reset = 1'b1;
        i_req = 4'b0001;
        i_data = 32'h0000_00A5;
        wait_grant(ok, t);
        check("single_seen", 32'(ok), 32'h1);
        check("single_ack", 32'(o_ack), 32'h1);
        check("single_data", 32'(o_tx_data), 32'hA5);
        check("single_gid", 32'(o_grant_id), 32'h0);
        check("single_busy", 32'(o_busy), 32'h1);
        i_req = 4'b0000;
        @(negedge clk);
        check("single_en_pulse", 32'(o_tx_en), 32'h0);
        check("single_ack_pulse", 32'(o_ack), 32'h0);
        wait_idle(ok, t);
        t = t + 0;
        check("single_idle_seen", 32'(ok), 32'h1);
        check("single_frame_ticks", 32'(t), 32'(FRAME + GAPT));
        check("single_hold_data", 32'(o_tx_data), 32'hA5);
        en_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_tx_en) en_cnt++;
        end
        check("single_no_regrant", 32'(en_cnt), 32'h0);

        // All four requesting from reset: 0,1,2,3,0
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        i_data = 32'h4433_2211;
        i_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(ok, t);
            check($sformatf("rr_seen%0d", k), 32'(ok), 32'h1);
            check($sformatf("rr_gid%0d", k), 32'(o_grant_id), 32'(gid_a[k]));
            check($sformatf("rr_data%0d", k), 32'(o_tx_data), 32'(dat_a[k]));
            check($sformatf("rr_ack%0d", k), 32'(o_ack), 32'h1 << gid_a[k]);
            if (k > 0)
                check($sformatf("rr_space%0d(t=%0d)", k, t), 32'(t >= SPACE && t <= SPACE + 1), 32'h1);
        end
        i_req = 4'b0000;
        wait_idle(ok, t);
        check("rr_idle_seen", 32'(ok), 32'h1);

        // Requests 1 and 3 with pointer at 0: 1,3,1
        i_req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            wait_grant(ok, t);
            check($sformatf("alt_seen%0d", k), 32'(ok), 32'h1);
            check($sformatf("alt_gid%0d", k), 32'(o_grant_id), 32'(gid_b[k]));
            check($sformatf("alt_data%0d", k), 32'(o_tx_data), 32'(dat_b[k]));
        end
        i_req = 4'b0000;
        wait_idle(ok, t);
        check("alt_idle_seen", 32'(ok), 32'h1);

        // Lone requester 0 wins with pointer at 1; bit 2 toggles mid-frame
        i_req = 4'b0001;
        wait_grant(ok, t);
        check("lone_seen", 32'(ok), 32'h1);
        check("lone_gid", 32'(o_grant_id), 32'h0);
        check("lone_data", 32'(o_tx_data), 32'h11);
        bad_ack = 1'b0;
        bad_en = 1'b0;
        bad_data = 1'b0;
        for (int k = 0; k < 100; k++) begin
            i_req = (k % 2 == 1) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            if (o_ack != 4'b0000) bad_ack = 1'b1;
            if (o_tx_en) bad_en = 1'b1;
            if (o_tx_data != 8'h11) bad_data = 1'b1;
        end
        check("toggle_no_ack", 32'(bad_ack), 32'h0);
        check("toggle_no_en", 32'(bad_en), 32'h0);
        check("toggle_data_held", 32'(bad_data), 32'h0);
        i_req = 4'b0100;
        wait_grant(ok, t);
        check("after_toggle_seen", 32'(ok), 32'h1);
        check("after_toggle_gid", 32'(o_grant_id), 32'h2);
        check("after_toggle_data", 32'(o_tx_data), 32'h33);
        i_req = 4'b0000;

        // Reset at tick 80 of a frame
        t = 0;
        for (int c = 0; c < BUDGET && t < 80; c++) begin
            @(negedge clk);
            if (i_clk_tx) t++;
        end
        check("mid_busy_before_rst", 32'(o_busy), 32'h1);
        reset = 1'b0;
        #1;
        check("async_tx_data", 32'(o_tx_data), 32'h00);
        check("async_gid", 32'(o_grant_id), 32'h3);
        check("async_busy", 32'(o_busy), 32'h0);
        check("async_ack", 32'(o_ack), 32'h0);
        check("async_tx_en", 32'(o_tx_en), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        en_cnt = 0;
        bad_ack = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (o_tx_en) en_cnt++;
            if (o_ack != 4'b0000) bad_ack = 1'b1;
        end
        check("post_rst_no_en", 32'(en_cnt), 32'h0);
        check("post_rst_no_ack", 32'(bad_ack), 32'h0);

        // Request held through reset: grant only on first edge after release
        reset = 1'b0;
        i_req = 4'b0001;
        en_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_tx_en) en_cnt++;
        end
        check("in_rst_no_en", 32'(en_cnt), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("first_edge_en", 32'(o_tx_en), 32'h1);
        check("first_edge_gid", 32'(o_grant_id), 32'h0);
        i_req = 4'b0000;
        wait_idle(ok, t);
        check("final_idle_seen", 32'(ok), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
